// File: rtl/period_to_freq_if.sv
// Request/result bundle between the period counter and the period-to-frequency divider.
// The master issues a divide request; the slave (divider) returns the registered result.
interface period_to_freq_if #(
  parameter int unsigned WIDTH = 32
);

  logic             start_i;
  logic [WIDTH-1:0] period_i;
  logic [WIDTH-1:0] freq_o;
  logic [WIDTH-1:0] remainder_o;
  logic             div_zero_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output start_i,
    output period_i,
    input  freq_o,
    input  remainder_o,
    input  div_zero_o,
    input  busy_o,
    input  done_o
  );

  modport slave (
    input  start_i,
    input  period_i,
    output freq_o,
    output remainder_o,
    output div_zero_o,
    output busy_o,
    output done_o
  );

endinterface

// File: rtl/period_to_freq.sv
// Period-to-frequency converter: freq = DIVIDEND / period using a radix-2 restoring divider,
// one quotient bit per clock. A zero period yields an all-ones result with div_zero set.
// Optional round-to-nearest stage is compiled in when PERIOD_TO_FREQ_ROUND_EN is defined;
// otherwise the quotient is truncated.
module period_to_freq #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] DIVIDEND = 1_000_000
) (
  input logic               clk_i,
  input logic               reset_i,
  period_to_freq_if.slave   bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StDiv,
    StRound,
    StDone
  } state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  quot_q;
  logic [WIDTH-1:0]  rem_q;
  logic [WIDTH-1:0]  div_q;
  logic [CntW-1:0]   cnt_q;
  logic              zero_q;

  logic [WIDTH-1:0]  freq_q;
  logic [WIDTH-1:0]  rem_out_q;
  logic              div_zero_q;
  logic              busy_q;
  logic              done_q;

  logic [WIDTH:0]    rem_shift;
  logic [WIDTH:0]    trial;
  logic              trial_neg;
  logic [WIDTH-1:0]  rem_step;
  logic [WIDTH-1:0]  quot_step;

  // One restoring step: shift {rem, quot} left, trial-subtract the divisor at WIDTH+1 bits.
  always_comb begin
    rem_shift = {rem_q, quot_q[WIDTH-1]};
    trial     = rem_shift - {1'b0, div_q};
    trial_neg = trial[WIDTH];
    rem_step  = trial_neg ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
    quot_step = {quot_q[WIDTH-2:0], ~trial_neg};
  end

`ifdef PERIOD_TO_FREQ_ROUND_EN
  logic              round_up;
  logic [WIDTH-1:0]  quot_rounded;

  // Round half up: 2*rem >= divisor, with the increment saturating at all ones.
  always_comb begin
    round_up     = ({rem_q, 1'b0} >= {1'b0, div_q});
    quot_rounded = quot_q;
    if (round_up && !(&quot_q)) begin
      quot_rounded = quot_q + 1'b1;
    end
  end
`endif

  // Divider FSM with registered busy/done and result registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      quot_q     <= '0;
      rem_q      <= '0;
      div_q      <= '0;
      cnt_q      <= '0;
      zero_q     <= 1'b0;
      freq_q     <= '0;
      rem_out_q  <= '0;
      div_zero_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start_i) begin
            div_q  <= bus.period_i;
            busy_q <= 1'b1;
            if (bus.period_i == '0) begin
              // Divide by zero skips the datapath and reports a saturated result.
              quot_q  <= '1;
              rem_q   <= '0;
              zero_q  <= 1'b1;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              quot_q  <= DIVIDEND;
              rem_q   <= '0;
              zero_q  <= 1'b0;
              cnt_q   <= CntW'(WIDTH - 1);
              state_q <= StDiv;
            end
          end
        end

        StDiv: begin
          rem_q  <= rem_step;
          quot_q <= quot_step;
          if (cnt_q == '0) begin
`ifdef PERIOD_TO_FREQ_ROUND_EN
            state_q <= StRound;
`else
            done_q  <= 1'b1;
            state_q <= StDone;
`endif
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        StRound: begin
`ifdef PERIOD_TO_FREQ_ROUND_EN
          // Remainder is left untouched so the reported value is the pre-round one.
          quot_q  <= quot_rounded;
          done_q  <= 1'b1;
          state_q <= StDone;
`else
          state_q <= StIdle;
`endif
        end

        StDone: begin
          freq_q     <= quot_q;
          rem_out_q  <= rem_q;
          div_zero_q <= zero_q;
          done_q     <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= StIdle;
        end

        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.freq_o      = freq_q;
  assign bus.remainder_o = rem_out_q;
  assign bus.div_zero_o  = div_zero_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;

endmodule

// File: doc/period_to_freq.md
# period_to_freq

Sequential divider stage that sits directly downstream of the period counter in the auto-scaled low-frequency counter. On each completed period measurement it converts the period count (in microsecond units) into a frequency: `freq = DIVIDEND / period`. The result and a one-cycle done pulse go on to the BCD conversion and display stages. A radix-2 restoring algorithm produces one quotient bit per clock.

## Interface
- `WIDTH`, default 32: width of the period input, the quotient and the remainder.
- `DIVIDEND`, default 1_000_000: numerator constant. It must fit in `WIDTH` bits and is the number of period units per second.
- `clk_i`, input, 1: clock.
- `reset_i`, input, 1: reset; asynchronous, active-high.
- `start_i`, input, 1: single-cycle request. Connected to the period counter's done pulse.
- `period_i`, input, WIDTH: divisor. Sampled only in the cycle `start_i` is accepted.
- `freq_o`, output, WIDTH: quotient. Registered; holds its value until the next result.
- `remainder_o`, output, WIDTH: remainder of the division. Registered.
- `div_zero_o`, output, 1: high with the result when `period_i` was 0. Held with the result.
- `busy_o`, output, 1: high in every state except IDLE.
- `done_o`, output, 1: one-cycle pulse in the DONE state.

## Operation
- **Reset:**
  - State goes to IDLE.
  - `freq_o`, `remainder_o`, `div_zero_o`, `busy_o` and `done_o` are all 0.
  - Internal quotient, remainder, divisor and bit counter are cleared.
- **States:** IDLE, DIV, ROUND (only with the macro defined), DONE.
- **IDLE:**
  - `start_i`=1 with `period_i`≠0: latch the divisor, load quotient register = `DIVIDEND`, remainder = 0, bit counter = `WIDTH`-1, go to DIV.
  - `start_i`=1 with `period_i`=0: go to DONE with the zero flag set.
- **DIV:** each cycle performs one restoring step.
  - Shift {remainder, quotient} left by one bit.
  - Trial subtract: remainder − divisor, computed at `WIDTH`+1 bits.
  - Trial result not negative: keep it and set quotient LSB to 1.
  - Trial result negative: restore the remainder and set quotient LSB to 0.
  - After the step with bit counter = 0, go to ROUND, or to DONE when ROUND is compiled out.
  - Otherwise decrement the bit counter.
- **DONE:**
  - `done_o`=1.
  - Update `freq_o`, `remainder_o` and `div_zero_o` from the internal registers. Result registers change only here.
  - Return to IDLE next cycle.
- **Divide by zero result:** `freq_o` = all ones, `remainder_o` = 0, `div_zero_o` = 1.
- **`start_i` while `busy_o`=1:** ignored. No queuing and no restart.
- **`start_i` in the DONE cycle:** ignored. The block accepts a start only in IDLE.
- **Reset asserted mid-division:** aborts immediately. Outputs return to reset values and no `done_o` is produced.
- **Width:** the quotient cannot exceed `DIVIDEND`, so there is no quotient overflow.

## Timing
- Start accepted at cycle N.
- DIV occupies cycles N+1 … N+`WIDTH`.
- Without `ROUND_EN`: DONE at cycle N+`WIDTH`+1. Outputs are valid from cycle N+`WIDTH`+2 and held. Default latency: 33 cycles to `done_o`.
- With `ROUND_EN`: ROUND at N+`WIDTH`+1, DONE at N+`WIDTH`+2.
- Divide-by-zero: DONE at N+1.
- Back-to-back: the next start is accepted in the IDLE cycle following DONE at the earliest.
- `busy_o` is high from cycle N+1 through the DONE cycle inclusive.

## Configuration
- **Macro `PERIOD_TO_FREQ_ROUND_EN` defined:** the ROUND state is compiled in. During ROUND:
  - If 2·remainder ≥ divisor (compared at `WIDTH`+1 bits), quotient is incremented. The increment saturates at all ones.
  - `remainder_o` then reports the pre-round remainder.
  - Latency grows by 1 cycle.
- **Macro not defined:** truncating division, no ROUND state, latency as above.

## Test plan
- `period_i`=1000, start → `done_o` exactly 33 cycles later (34 with ROUND); `freq_o`=1000, `remainder_o`=0, `div_zero_o`=0.
- `period_i`=6 → `remainder_o`=4. `freq_o`=166666 without the macro; 166667 with `PERIOD_TO_FREQ_ROUND_EN`.
- `period_i`=1 → `freq_o`=1000000, `remainder_o`=0. `period_i`=3 → `freq_o`=333333, `remainder_o`=1, with or without rounding.
- `period_i`=0 → `done_o` 1 cycle after start (cycle N+1); `freq_o`=0xFFFFFFFF, `div_zero_o`=1.
- Start with 7, then pulse `start_i` with 1000 at cycle N+5 and in the DONE cycle → only one `done_o`; `freq_o`=142857, `remainder_o`=1.
- `reset_i` asserted at cycle N+10 of a division → all outputs 0 immediately, no `done_o`. A new start after release completes normally.
